// File: rtl/pow2_serial_ctrl_if.sv
// Handshake bundle for pow2_serial_ctrl: word input (valid/ready + x),
// result output (valid/ready + z/exp) and the busy status flag.
// The slave modport is the detector side; master is the producer/consumer side.
interface pow2_serial_ctrl_if #(
    parameter int N = 8
);
    localparam int EW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic          out_valid;
    logic          out_ready;
    logic          z;
    logic [EW-1:0] exp;
    logic          busy;

    modport master (
        output in_valid,
        output x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  z,
        input  exp,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output z,
        output exp,
        output busy
    );
endinterface

// File: rtl/pow2_serial_ctrl.sv
// pow2_serial_ctrl: handshaked, bit-serial power-of-two detector.
// A word accepted in IDLE is shifted out LSB first, one bit per clock, while
// a saturating ones counter (0,1,2+) and the index of the first set bit are
// tracked. In DONE the result is presented until the consumer takes it.
// Optional build macro POW2_EARLY_EXIT_EN: leave SCAN as soon as a second
// set bit is seen or no set bits remain, giving a 1..N cycle scan.
// Without the macro every scan lasts exactly N clocks.
module pow2_serial_ctrl #(
    parameter int N = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    pow2_serial_ctrl_if.slave bus
);
    localparam int EW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ones counter saturates at 2: only "none", "exactly one" and
    // "more than one" matter for the power-of-two decision.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        logic [1:0] r;
        if (v == 2'd2) begin
            r = 2'd2;
        end else begin
            r = v + 2'd1;
        end
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic [1:0]    ones_q, ones_d;
    logic [EW-1:0] exp_q, exp_d;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          busy_s;
    logic          z_s;
    logic [EW-1:0] exp_s;
    logic          accept_s;
    logic          scan_last_s;

    assign accept_s = bus.in_valid & in_ready_s;

    // Decide whether the current scan edge is the final one.
`ifdef POW2_EARLY_EXIT_EN
    assign scan_last_s = (cnt_q == EW'(N - 1)) || (ones_d == 2'd2) || (sh_d == '0);
`else
    assign scan_last_s = (cnt_q == EW'(N - 1));
`endif

    // State register with asynchronous clear of all scan state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            ones_q  <= 2'd0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            exp_q   <= exp_d;
        end
    end

    // Next-state logic for the IDLE -> SCAN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: load on accept, shift and count while scanning.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        ones_d = ones_q;
        exp_d  = exp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sh_d   = bus.x;
                    cnt_d  = '0;
                    ones_d = 2'd0;
                    exp_d  = '0;
                end else begin
                    sh_d   = sh_q;
                end
            end
            ST_SCAN: begin
                sh_d  = {1'b0, sh_q[N-1:1]};
                cnt_d = cnt_q + EW'(1);
                if (sh_q[0]) begin
                    ones_d = sat_inc2(ones_q);
                    // Only the first set bit defines the exponent.
                    if (ones_q == 2'd0) begin
                        exp_d = cnt_q;
                    end else begin
                        exp_d = exp_q;
                    end
                end else begin
                    ones_d = ones_q;
                end
            end
            ST_DONE: begin
                sh_d = sh_q;
            end
            default: begin
                sh_d = sh_q;
            end
        endcase
    end

    // Output decode from registered state; in_ready is held low during reset.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        z_s         = 1'b0;
        exp_s       = '0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = reset_n;
            end
            ST_SCAN: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                busy_s      = 1'b1;
                out_valid_s = 1'b1;
                if (ones_q == 2'd1) begin
                    z_s   = 1'b1;
                    exp_s = exp_q;
                end else begin
                    z_s   = 1'b0;
                    exp_s = '0;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.busy      = busy_s;
    assign bus.z         = z_s;
    assign bus.exp       = exp_s;

endmodule

// File: tb/tb_pow2_serial_ctrl.sv
// Self-checking bench for pow2_serial_ctrl (N=8): directed table of words,
// hand-written hold/reset sequences, then random words against a model.
module tb_pow2_serial_ctrl;
    localparam int N  = 8;
    localparam int EW = $clog2(N);

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pow2_serial_ctrl_if #(.N(N)) bus ();

    pow2_serial_ctrl #(.N(N)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  x;
        logic          z;
        logic [EW-1:0] e;
        int            lat_early;
        int            hold;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: count set bits, find first/second/highest set positions.
    function automatic void model(input logic [N-1:0] xv, output logic ez,
                                  output logic [EW-1:0] ee, output int lat);
        int ones;
        int first;
        int second;
        int msb;
        ones = 0; first = 0; second = 0; msb = 0;
        for (int i = 0; i < N; i++) begin
            if (xv[i]) begin
                if (ones == 0) first = i;
                if (ones == 1) second = i;
                ones++;
                msb = i;
            end
        end
        ez = (ones == 1);
        ee = ez ? EW'(first) : '0;
        lat = exp_lat(ones >= 2 ? second + 1 : (ones == 1 ? msb + 1 : 1));
    endfunction

    function automatic int exp_lat(input int early);
`ifdef POW2_EARLY_EXIT_EN
        return early;
`else
        return N + 0 * early;
`endif
    endfunction

    task automatic do_word(input logic [N-1:0] xv, input logic ez, input logic [EW-1:0] ee,
                           input int elat, input int hold, input bit inject);
        int lat;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_busy", bus.busy, 0);
        bus.in_valid  = 1'b1;
        bus.x         = xv;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = N'($urandom);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < N + 4) begin
            check("scan_in_ready", bus.in_ready, 0);
            check("scan_busy", bus.busy, 1);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, elat);
        check("out_valid", bus.out_valid, 1);
        check("z", bus.z, ez);
        check("exp", bus.exp, ee);
        check("done_in_ready", bus.in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            if (inject && k == 1) begin
                bus.in_valid = 1'b1;
                bus.x        = 8'h02;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_z", bus.z, ez);
            check("hold_exp", bus.exp, ee);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          mz;
        logic [EW-1:0] me;
        int            ml;
        logic [N-1:0]  rx;
        bit            stale;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{8'h80, 1'b1, 3'd7, 8, 0};
        tbl[1] = '{8'h01, 1'b1, 3'd0, 1, 0};
        tbl[2] = '{8'h00, 1'b0, 3'd0, 1, 0};
        tbl[3] = '{8'h20, 1'b1, 3'd5, 6, 0};
        tbl[4] = '{8'h5A, 1'b0, 3'd0, 4, 0};
        tbl[5] = '{8'hC0, 1'b0, 3'd0, 8, 0};
        tbl[6] = '{8'hFF, 1'b0, 3'd0, 2, 0};
        tbl[7] = '{8'h03, 1'b0, 3'd0, 2, 1};
        tbl[8] = '{8'h04, 1'b1, 3'd2, 3, 2};
        tbl[9] = '{8'h40, 1'b1, 3'd6, 7, 3};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_z", bus.z, 0);
        check("rst_exp", bus.exp, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_word(tbl[i].x, tbl[i].z, tbl[i].e, exp_lat(tbl[i].lat_early), tbl[i].hold, 1'b0);
        end

        // Stalled consumer with an ignored in_valid pulse inside the window
        do_word(8'h10, 1'b1, 3'd4, exp_lat(5), 5, 1'b1);
        stale = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) stale = 1'b1;
        end
        check("no_extra_result", stale, 0);

        // Asynchronous reset in the middle of a scan
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.x         = 8'h08;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy", bus.busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_z", bus.z, 0);
        check("arst_exp", bus.exp, 0);
        check("arst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", bus.in_ready, 1);
        stale = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("no_stale_result", stale, 0);

        // Randomised words against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       rx = N'(1) << $urandom_range(0, N - 1);
                1:       rx = ($urandom_range(0, 1) == 0) ? '0 : (N'(1) << $urandom_range(0, N - 1)) | N'(1);
                default: rx = N'($urandom);
            endcase
            model(rx, mz, me, ml);
            do_word(rx, mz, me, ml, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
